// File: rtl/fpa_pkg.sv
// fpa_pkg: float field positions, class flag indices and a result classifier
package fpa_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_HI = 30;
  localparam int EXP_LO = 23;
  localparam int FRAC_HI = 22;
  localparam int FLG_NAN = 3;
  localparam int FLG_INF = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_SUB = 0;
  function automatic logic [3:0] classify(input logic [31:0] w);
    logic [7:0] e;
    logic f;
    e = w[EXP_HI:EXP_LO];
    f = |w[FRAC_HI:0];
    classify = '0;
    classify[FLG_NAN] = &e & f;
    classify[FLG_INF] = &e & ~f;
    classify[FLG_ZERO] = ~|e & ~f;
    classify[FLG_SUB] = ~|e & f;
  endfunction
endpackage

// File: rtl/fpa_res_fifo.sv
// fpa_res_fifo: first-word-fall-through result FIFO with registered head storage
module fpa_res_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 40
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic                       out_valid,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [OW-1:0] occ_q, occ_d;
  logic do_pop;
  always_comb begin
    do_pop = pop & (occ_q != '0);
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(do_pop);
    occ_d = occ_q + OW'(push) - OW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
    end
  end
  assign out_valid = occ_q != '0;
  assign head = mem_q[rd_q];
  assign occupancy = occ_q;
endmodule

// File: rtl/fpa_result_collector.sv
// fpa_result_collector: tags adder issues, captures and classifies results, credit-gated FIFO
module fpa_result_collector
  import fpa_pkg::*;
#(
  parameter int FPA_LAT = 7,
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_valid,
  input  logic [TAG_W-1:0]       iss_tag,
  output logic                   iss_ready,
  input  logic [31:0]            fpa_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   err_iss
);
  localparam int OW = $clog2(DEPTH) + 1;
  localparam int CW = OW + 1;
  localparam int W = 32 + TAG_W + 4;
  logic [FPA_LAT-1:0] vld_q, vld_d;
  logic [FPA_LAT-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [OW-1:0] infl_q, infl_d;
  logic err_q, err_d;
  logic acc, cap;
  logic [W-1:0] head;
  // credit counts both queued and in-flight results so a capture always has a slot
  assign iss_ready = (CW'(occupancy) + CW'(infl_q)) < CW'(DEPTH);
  always_comb begin
    acc = iss_valid & iss_ready;
    cap = vld_q[FPA_LAT-1];
    vld_d = {vld_q[FPA_LAT-2:0], acc};
    tag_d = {tag_q[FPA_LAT-2:0], iss_tag};
    infl_d = infl_q + OW'(acc) - OW'(cap);
    err_d = err_q | (iss_valid & ~iss_ready);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      tag_q <= '0;
      infl_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      infl_q <= infl_d;
      err_q <= err_d;
    end
  end
  fpa_res_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (cap),
    .push_data({fpa_c, tag_q[FPA_LAT-1], classify(fpa_c)}),
    .pop      (out_ready),
    .out_valid(out_valid),
    .head     (head),
    .occupancy(occupancy)
  );
  assign {out_data, out_tag, out_flags} = head;
  assign err_iss = err_q;
endmodule

// File: tb/tb_fpa_result_collector.sv
// tb_fpa_result_collector: directed scenario tasks with hand-computed expectations
module tb_fpa_result_collector;
  localparam int FPA_LAT = 7;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic iss_valid = 1'b0;
  logic [TAG_W-1:0] iss_tag = '0;
  logic iss_ready;
  logic [31:0] iss_res = '0;
  logic [31:0] fpa_c;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [3:0] out_flags;
  logic [$clog2(DEPTH):0] occupancy;
  logic err_iss;
  logic [FPA_LAT-1:0][31:0] pipe = '0;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  // stand-in for the adder: the operand's intended result emerges FPA_LAT edges later
  always @(posedge clk) pipe <= {pipe[FPA_LAT-2:0], iss_res};
  assign fpa_c = pipe[FPA_LAT-1];
  fpa_result_collector #(.FPA_LAT(FPA_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_tag(iss_tag), .iss_ready(iss_ready),
    .fpa_c(fpa_c), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_flags(out_flags), .occupancy(occupancy), .err_iss(err_iss)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    vecs += 7;
    if (iss_ready !== 1'b1) begin errs++; $display("FAIL reset iss_ready got %b want 1", iss_ready); end
    if (out_valid !== 1'b0) begin errs++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (out_data !== 32'h0) begin errs++; $display("FAIL reset out_data got %h want 0", out_data); end
    if (out_tag !== 4'h0) begin errs++; $display("FAIL reset out_tag got %h want 0", out_tag); end
    if (out_flags !== 4'h0) begin errs++; $display("FAIL reset out_flags got %b want 0", out_flags); end
    if (occupancy !== 4'd0) begin errs++; $display("FAIL reset occupancy got %0d want 0", occupancy); end
    if (err_iss !== 1'b0) begin errs++; $display("FAIL reset err_iss got %b want 0", err_iss); end
  endtask
  task automatic test_single;
    iss_valid = 1'b1; iss_tag = 4'd3; iss_res = 32'h4561_0000;
    tick;
    iss_valid = 1'b0; iss_res = 32'hDEAD_BEEF;
    repeat (6) tick;
    vecs++;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL single early out_valid got %b want 0", out_valid); end
    tick;
    vecs += 5;
    if (out_valid !== 1'b1) begin errs++; $display("FAIL single out_valid got %b want 1", out_valid); end
    if (out_data !== 32'h4561_0000) begin errs++; $display("FAIL single out_data got %h want 45610000", out_data); end
    if (out_tag !== 4'd3) begin errs++; $display("FAIL single out_tag got %0d want 3", out_tag); end
    if (out_flags !== 4'b0000) begin errs++; $display("FAIL single out_flags got %b want 0000", out_flags); end
    if (occupancy !== 4'd1) begin errs++; $display("FAIL single occupancy got %0d want 1", occupancy); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vecs += 2;
    if (out_valid !== 1'b0) begin errs++; $display("FAIL single pop out_valid got %b want 0", out_valid); end
    if (occupancy !== 4'd0) begin errs++; $display("FAIL single pop occupancy got %0d want 0", occupancy); end
  endtask
  task automatic test_class;
    logic [31:0] vals [5];
    logic [3:0] flg [5];
    vals = '{32'h7F80_0000, 32'h7FC0_0001, 32'h0000_0000, 32'h0000_0001, 32'h3F80_0000};
    flg = '{4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      iss_valid = 1'b1; iss_tag = 4'(i); iss_res = vals[i];
      tick;
    end
    iss_valid = 1'b0;
    repeat (7) tick;
    for (int i = 0; i < 5; i++) begin
      vecs += 3;
      if (out_data !== vals[i]) begin errs++; $display("FAIL class[%0d] out_data got %h want %h", i, out_data, vals[i]); end
      if (out_tag !== 4'(i)) begin errs++; $display("FAIL class[%0d] out_tag got %0d want %0d", i, out_tag, i); end
      if (out_flags !== flg[i]) begin errs++; $display("FAIL class[%0d] out_flags got %b want %b", i, out_flags, flg[i]); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    vecs++;
    if (occupancy !== 4'd0) begin errs++; $display("FAIL class drain occupancy got %0d want 0", occupancy); end
  endtask
  task automatic test_simul;
    for (int i = 1; i <= 5; i++) begin
      iss_valid = 1'b1; iss_tag = 4'(i); iss_res = 32'h4200_0000 + 32'(i);
      tick;
    end
    iss_valid = 1'b0;
    repeat (6) tick;
    vecs += 2;
    if (occupancy !== 4'd4) begin errs++; $display("FAIL simul pre occupancy got %0d want 4", occupancy); end
    if (out_tag !== 4'd1) begin errs++; $display("FAIL simul pre out_tag got %0d want 1", out_tag); end
    out_ready = 1'b1;
    tick;
    vecs += 2;
    if (occupancy !== 4'd4) begin errs++; $display("FAIL simul occupancy got %0d want 4", occupancy); end
    if (out_tag !== 4'd2) begin errs++; $display("FAIL simul out_tag got %0d want 2", out_tag); end
    repeat (4) tick;
    out_ready = 1'b0;
    vecs++;
    if (occupancy !== 4'd0) begin errs++; $display("FAIL simul drain occupancy got %0d want 0", occupancy); end
  endtask
  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      iss_valid = 1'b1; iss_tag = 4'(8 + i); iss_res = 32'h4000_0000 + 32'(i);
      tick;
      vecs++;
      if (iss_ready !== (i < 7)) begin errs++; $display("FAIL b2b iss_ready after accept %0d got %b want %b", i + 1, iss_ready, i < 7); end
    end
    iss_valid = 1'b0;
    repeat (6) tick;
    vecs++;
    if (occupancy !== 4'd7) begin errs++; $display("FAIL b2b edge13 occupancy got %0d want 7", occupancy); end
    tick;
    vecs += 2;
    if (occupancy !== 4'd8) begin errs++; $display("FAIL b2b edge14 occupancy got %0d want 8", occupancy); end
    if (iss_ready !== 1'b0) begin errs++; $display("FAIL b2b full iss_ready got %b want 0", iss_ready); end
    iss_valid = 1'b1; iss_tag = 4'd0; iss_res = 32'h7777_7777;
    tick;
    iss_valid = 1'b0;
    vecs += 2;
    if (err_iss !== 1'b1) begin errs++; $display("FAIL err err_iss got %b want 1", err_iss); end
    if (occupancy !== 4'd8) begin errs++; $display("FAIL err occupancy got %0d want 8", occupancy); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vecs += 2;
    if (occupancy !== 4'd7) begin errs++; $display("FAIL b2b pop occupancy got %0d want 7", occupancy); end
    if (iss_ready !== 1'b1) begin errs++; $display("FAIL b2b pop iss_ready got %b want 1", iss_ready); end
    repeat (8) tick;
    vecs += 2;
    if (occupancy !== 4'd7) begin errs++; $display("FAIL err no extra entry occupancy got %0d want 7", occupancy); end
    if (err_iss !== 1'b1) begin errs++; $display("FAIL err sticky err_iss got %b want 1", err_iss); end
    for (int i = 1; i < 8; i++) begin
      vecs += 2;
      if (out_tag !== 4'(8 + i)) begin errs++; $display("FAIL b2b drain out_tag got %0d want %0d", out_tag, 8 + i); end
      if (out_data !== 32'h4000_0000 + 32'(i)) begin errs++; $display("FAIL b2b drain out_data got %h want %h", out_data, 32'h4000_0000 + 32'(i)); end
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
    vecs++;
    if (occupancy !== 4'd0) begin errs++; $display("FAIL b2b drain occupancy got %0d want 0", occupancy); end
  endtask
  task automatic test_reset_flight;
    for (int i = 0; i < 5; i++) begin
      iss_valid = 1'b1; iss_tag = 4'(6 + i); iss_res = 32'h4400_0000 + 32'(i);
      tick;
    end
    iss_valid = 1'b0;
    repeat (4) tick;
    vecs++;
    if (occupancy !== 4'd2) begin errs++; $display("FAIL rflight queued occupancy got %0d want 2", occupancy); end
    #2 rst = 1'b0;
    #1;
    test_reset;
    tick;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      vecs += 2;
      if (occupancy !== 4'd0) begin errs++; $display("FAIL rflight stale occupancy got %0d want 0", occupancy); end
      if (out_valid !== 1'b0) begin errs++; $display("FAIL rflight stale out_valid got %b want 0", out_valid); end
    end
  endtask
  initial begin
    repeat (3) tick;
    test_reset;
    rst = 1'b1;
    tick;
    test_single;
    test_class;
    test_simul;
    test_back_to_back;
    test_reset_flight;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
